// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Two-requester arbiter in front of one shared, purely combinational ALU.
//   A granted request has its operands and opcode captured. The ALU is then
//   driven from those registers for one EXEC cycle, and its result is
//   registered. The result is held in RESP until the consumer takes it.
//   Only one operation is in flight at a time.
//
//   When both requesters are valid in IDLE, the tie goes to the requester
//   that did not win the previous grant (round-robin).
//
// Optional feature:
//   ALU_ARB_FIXED_PRIO_EN  - when defined, requester 0 always wins a tie and
//                            no last-grant history is kept.
//
// Ports:
//   clk                  in   clock, all state updates on rising edge
//   rst_n                in   asynchronous active-low reset
//   req0_valid/req1_valid   in   requester has an operation pending
//   req0_ready/req1_ready   out  requester accepted this cycle (IDLE only)
//   req0_a/req0_b/req0_op   in   requester 0 operands and opcode
//   req1_a/req1_b/req1_op   in   requester 1 operands and opcode
//   alu_a/alu_b/alu_op      out  shared ALU operands/opcode (from capture regs)
//   alu_res              in   shared ALU result (combinational)
//   rsp_valid            out  response available (RESP state)
//   rsp_ready            in   consumer takes response
//   rsp_id               out  requester that issued the operation
//   rsp_data             out  registered ALU result
//   busy                 out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [1:0]          r_op;
    logic                r_id;
    logic [DATA_W-1:0]   r_rsp_data;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                r_last_grant;
`endif

    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept0;
    logic                w_accept1;

    // -------------------------------------------------------------------------
    // Grant selection. This is computed every cycle, but it only takes effect
    // through the ready outputs, which are gated to IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && !req1_valid) begin
            w_grant0 = 1'b1;
        end else if (req1_valid && !req0_valid) begin
            w_grant1 = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_grant0 = 1'b1;
`else
            // The tie goes to the requester that was not granted last time.
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
`endif
        end
    end

    // Ready is qualified with rst_n. While reset is asserted the state is
    // already IDLE, so without this gate a ready could be raised during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (r_state == S_IDLE)) begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
        end
    end

    assign w_accept0 = req0_valid && req0_ready;
    assign w_accept1 = req1_valid && req1_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept0 || w_accept1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, capture and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (w_accept0) begin
                r_a          <= req0_a;
                r_b          <= req0_b;
                r_op         <= req0_op;
                r_id         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_last_grant <= 1'b0;
`endif
            end else if (w_accept1) begin
                r_a          <= req1_a;
                r_b          <= req1_b;
                r_op         <= req1_op;
                r_id         <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_last_grant <= 1'b1;
`endif
            end

            if (r_state == S_EXEC) begin
                r_rsp_data <= alu_res;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;

    assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 4, operand/result width; SHALL equal the shared ALU width (4).
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: req0_valid / req1_valid  in  1  requester i has an operation pending.
REQ-005 Ports: req0_ready / req1_ready  out  1  arbiter accepts requester i this cycle.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands; req0_op / req1_op  in  2  opcode.
REQ-007 Ports: alu_a, alu_b  out  DATA_W; alu_op  out  2  drive shared ALU; alu_res  in  DATA_W  ALU result, combinational.
REQ-008 Ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  originating requester; rsp_data  out  DATA_W.
REQ-009 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-010 FSM states IDLE, EXEC, RESP SHALL be the only states.
REQ-011 reqN_ready SHALL be combinational: high only in IDLE, for the granted requester only; at most one ready high per cycle.
REQ-012 Grant in IDLE: single valid wins; both valid -> requester other than last_grant wins (round-robin).
REQ-013 On reqN_valid && reqN_ready: capture a, b, op, id into registers, last_grant <= N, go EXEC.
REQ-014 alu_a/alu_b/alu_op SHALL always be driven from the capture registers, never from request ports directly.
REQ-015 EXEC (exactly 1 cycle): register alu_res into rsp_data, go RESP.
REQ-016 RESP: rsp_valid=1, rsp_id and rsp_data stable; on rsp_ready go IDLE; otherwise hold indefinitely.
REQ-017 One outstanding operation; no request accepted in EXEC or RESP; minimum accept-to-accept spacing 3 cycles.
REQ-018 Accept-to-rsp_valid latency SHALL be exactly 2 cycles.
REQ-019 Opcode passed unmodified: 00 add, 01 shift-left a by b, 1x bitwise AND; result truncated to DATA_W, carry discarded (15+1 -> 0).
REQ-020 Requesters SHALL hold valid and payload until ready; arbiter does not check withdrawal.
REQ-021 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, last_grant=1 (req0 wins first tie), capture registers 0, rsp_data 0, rsp_id 0.
REQ-023 Reset values: rsp_valid 0, busy 0, alu_a/alu_b/alu_op 0, both ready 0 while rst_n low.
REQ-024 Reset during EXEC or RESP SHALL abandon the operation; no response issued after release.

Configuration
REQ-025 Macro ALU_ARB_FIXED_PRIO_EN defined: tie always granted to requester 0, last_grant unused.
REQ-026 Macro undefined: round-robin per REQ-012; all other behaviour identical.

Verification
REQ-027 req0 a=3 b=4 op=00 -> req0_ready same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_data=7.
REQ-028 After reset both valid (req0 a=3,b=2,op=01; req1 a=15,b=1,op=00) -> first rsp id=0 data=12, second id=1 data=0.
REQ-029 rsp_ready low 5 cycles in RESP -> rsp_valid/id/data stable, both ready 0, busy 1; accept resumes cycle after rsp_ready.
REQ-030 Both valid continuously, 4 ops, rsp_ready tied 1 -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 rst_n low during EXEC of req1 a=6 b=5 op=10 -> rsp_valid 0, busy 0, no response after release; next tie grants req0.
